// File: rtl/rx_ts_queue.sv
// Timestamp capture queue: first-word-fall-through FIFO of PTP capture records with level interrupt and overflow count.
// Latency: a capture is visible at the head one cycle after its write edge; int_o is registered from next-state values.
// Backpressure: none; a capture into a full queue is dropped, or overwrites the oldest entry when RX_TS_OVERWRITE_EN is defined.
module rx_ts_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          rx_clk,
    input  logic          rx_rst_n,
    input  logic          rx_clk_en_i,
    input  logic          cap_valid_i,
    input  logic [79:0]   cap_ts_i,
    input  logic [15:0]   cap_seqid_i,
    input  logic [3:0]    cap_msgtype_i,
    input  logic [3:0]    cap_sdoid_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  logic          int_en_i,
    input  logic [AW:0]   thresh_i,
    output logic          out_valid_o,
    output logic [79:0]   out_ts_o,
    output logic [15:0]   out_seqid_o,
    output logic [3:0]    out_msgtype_o,
    output logic [3:0]    out_sdoid_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic [7:0]    ovf_cnt_o,
    output logic          int_o
);

    localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

    logic [79:0]   ts_mem  [DEPTH];
    logic [15:0]   seq_mem [DEPTH];
    logic [3:0]    mt_mem  [DEPTH];
    logic [3:0]    sd_mem  [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [AW:0]   level, level_nxt;
    logic [7:0]    ovf_cnt, ovf_nxt;
    logic          sticky, sticky_nxt;
    logic          int_q, int_nxt;
    logic          wr_en;
    logic          full, do_pop, ovf_evt;

    assign full    = (level == LVL_MAX);
    assign do_pop  = pop_i && (level != '0);
    // A pop in the same cycle frees a slot, so a full queue only overflows without one.
    assign ovf_evt = cap_valid_i && full && !do_pop;

    always_comb begin
        wr_nxt     = wr_ptr;
        rd_nxt     = rd_ptr;
        level_nxt  = level;
        ovf_nxt    = ovf_cnt;
        sticky_nxt = sticky;
        wr_en      = 1'b0;
        if (clr_i) begin
            wr_nxt     = '0;
            rd_nxt     = '0;
            level_nxt  = '0;
            ovf_nxt    = '0;
            sticky_nxt = 1'b0;
        end else if (ovf_evt) begin
            ovf_nxt    = (ovf_cnt == 8'hFF) ? ovf_cnt : ovf_cnt + 8'd1;
            sticky_nxt = 1'b1;
`ifdef RX_TS_OVERWRITE_EN
            // wr_ptr == rd_ptr when full: the new record replaces the oldest.
            wr_en  = 1'b1;
            wr_nxt = wr_ptr + 1'b1;
            rd_nxt = rd_ptr + 1'b1;
`endif
        end else begin
            if (cap_valid_i) begin
                wr_en  = 1'b1;
                wr_nxt = wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_nxt = rd_ptr + 1'b1;
            end
            if (cap_valid_i && !do_pop) begin
                level_nxt = level + 1'b1;
            end else if (!cap_valid_i && do_pop) begin
                level_nxt = level - 1'b1;
            end
        end
        int_nxt = int_en_i && (((thresh_i != '0) && (level_nxt >= thresh_i)) || sticky_nxt);
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= '0;
            sticky  <= 1'b0;
            int_q   <= 1'b0;
        end else if (rx_clk_en_i) begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            level   <= level_nxt;
            ovf_cnt <= ovf_nxt;
            sticky  <= sticky_nxt;
            int_q   <= int_nxt;
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i]  <= '0;
                seq_mem[i] <= '0;
                mt_mem[i]  <= '0;
                sd_mem[i]  <= '0;
            end
        end else if (rx_clk_en_i && wr_en) begin
            ts_mem[wr_ptr]  <= cap_ts_i;
            seq_mem[wr_ptr] <= cap_seqid_i;
            mt_mem[wr_ptr]  <= cap_msgtype_i;
            sd_mem[wr_ptr]  <= cap_sdoid_i;
        end
    end

    assign out_valid_o   = (level != '0);
    assign out_ts_o      = ts_mem[rd_ptr];
    assign out_seqid_o   = seq_mem[rd_ptr];
    assign out_msgtype_o = mt_mem[rd_ptr];
    assign out_sdoid_o   = sd_mem[rd_ptr];
    assign level_o       = level;
    assign full_o        = full;
    assign ovf_cnt_o     = ovf_cnt;
    assign int_o         = int_q;

endmodule

// File: tb/tb_rx_ts_queue.sv
// Testbench for rx_ts_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_rx_ts_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          rx_clk = 1'b0;
    logic          rx_rst_n = 1'b0;
    logic          rx_clk_en_i = 1'b0;
    logic          cap_valid_i = 1'b0;
    logic [79:0]   cap_ts_i = '0;
    logic [15:0]   cap_seqid_i = '0;
    logic [3:0]    cap_msgtype_i = '0;
    logic [3:0]    cap_sdoid_i = '0;
    logic          pop_i = 1'b0;
    logic          clr_i = 1'b0;
    logic          int_en_i = 1'b0;
    logic [AW:0]   thresh_i = '0;
    logic          out_valid_o;
    logic [79:0]   out_ts_o;
    logic [15:0]   out_seqid_o;
    logic [3:0]    out_msgtype_o;
    logic [3:0]    out_sdoid_o;
    logic [AW:0]   level_o;
    logic          full_o;
    logic [7:0]    ovf_cnt_o;
    logic          int_o;

    always #5 rx_clk = ~rx_clk;

    rx_ts_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_clk_en_i(rx_clk_en_i),
        .cap_valid_i(cap_valid_i), .cap_ts_i(cap_ts_i), .cap_seqid_i(cap_seqid_i),
        .cap_msgtype_i(cap_msgtype_i), .cap_sdoid_i(cap_sdoid_i),
        .pop_i(pop_i), .clr_i(clr_i), .int_en_i(int_en_i), .thresh_i(thresh_i),
        .out_valid_o(out_valid_o), .out_ts_o(out_ts_o), .out_seqid_o(out_seqid_o),
        .out_msgtype_o(out_msgtype_o), .out_sdoid_o(out_sdoid_o),
        .level_o(level_o), .full_o(full_o), .ovf_cnt_o(ovf_cnt_o), .int_o(int_o)
    );

    typedef struct packed {
        logic [79:0] ts;
        logic [15:0] seq;
        logic [3:0]  mt;
        logic [3:0]  sd;
    } ent_t;

    typedef struct {
        logic v;
        int   lvl;
        logic full;
        int   ovf;
        logic intr;
        ent_t head;
    } exp_t;

    ent_t mq[$];
    int   m_ovf = 0;
    bit   m_sticky = 0;
    bit   m_int = 0;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic ent_t mk(input logic [15:0] seq);
        ent_t e;
        e.ts  = {16'(seq), 32'(seq) * 32'd7, 32'h1000 + 32'(seq)};
        e.seq = seq;
        e.mt  = seq[3:0];
        e.sd  = ~seq[3:0];
        return e;
    endfunction

    // Drives one cycle at the falling edge and pushes the expected post-edge state.
    task automatic cyc(input bit rst, input bit en, input bit cap, input bit pop, input bit clr,
                       input bit ie, input int th, input ent_t e);
        exp_t x;
        @(negedge rx_clk);
        rx_rst_n      = !rst;
        rx_clk_en_i   = en;
        cap_valid_i   = cap;
        pop_i         = pop;
        clr_i         = clr;
        int_en_i      = ie;
        thresh_i      = th[AW:0];
        cap_ts_i      = e.ts;
        cap_seqid_i   = e.seq;
        cap_msgtype_i = e.mt;
        cap_sdoid_i   = e.sd;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_sticky = 0;
            m_int = 0;
        end else if (en) begin
            if (clr) begin
                mq.delete();
                m_ovf = 0;
                m_sticky = 0;
            end else begin
                if (pop && mq.size() > 0) void'(mq.pop_front());
                if (cap) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(e);
                    end else begin
                        if (m_ovf < 255) m_ovf++;
                        m_sticky = 1;
`ifdef RX_TS_OVERWRITE_EN
                        void'(mq.pop_front());
                        mq.push_back(e);
`endif
                    end
                end
            end
            m_int = ie && ((th != 0 && mq.size() >= th) || m_sticky);
        end
        x.v    = mq.size() > 0;
        x.lvl  = mq.size();
        x.full = (mq.size() == DEPTH);
        x.ovf  = m_ovf;
        x.intr = m_int;
        x.head = (mq.size() > 0) ? mq[0] : '0;
        exp_q.push_back(x);
    endtask

    task automatic settle();
        @(posedge rx_clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge rx_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", 80'(out_valid_o), 80'(e.v));
                chk("level", 80'(level_o), 80'(e.lvl));
                chk("full", 80'(full_o), 80'(e.full));
                chk("ovf_cnt", 80'(ovf_cnt_o), 80'(e.ovf));
                chk("int", 80'(int_o), 80'(e.intr));
                if (e.v) begin
                    chk("head_ts", out_ts_o, e.head.ts);
                    chk("head_seqid", 80'(out_seqid_o), 80'(e.head.seq));
                    chk("head_msgtype", 80'(out_msgtype_o), 80'(e.head.mt));
                    chk("head_sdoid", 80'(out_sdoid_o), 80'(e.head.sd));
                end
            end
        end
    end

    initial begin : stim
        ent_t e;
        ent_t z;
        bit ie;
        int exp_head;
        z = '0;
        ie = 0;

        repeat (2) @(posedge rx_clk);
        #2;
        chk("rst_level", 80'(level_o), 80'd0);
        chk("rst_valid", 80'(out_valid_o), 80'd0);
        chk("rst_ts", out_ts_o, 80'd0);
        chk("rst_seqid", 80'(out_seqid_o), 80'd0);
        chk("rst_ovf", 80'(ovf_cnt_o), 80'd0);
        chk("rst_full_int", 80'({full_o, int_o}), 80'd0);

        e.ts = 80'h000000000001_3B9AC9FF;
        e.seq = 16'h0005;
        e.mt = 4'h0;
        e.sd = 4'h0;
        cyc(0, 1, 1, 0, 0, 0, 0, e);
        settle();
        chk("first_valid", 80'(out_valid_o), 80'd1);
        chk("first_ts", out_ts_o, 80'h000000000001_3B9AC9FF);
        chk("first_seqid", 80'(out_seqid_o), 80'h5);
        chk("first_level", 80'(level_o), 80'd1);

        cyc(0, 1, 0, 0, 1, 0, 0, z);
        for (int i = 1; i <= 5; i++) cyc(0, 1, 1, 0, 0, 0, 0, mk(16'(i)));
        settle();
`ifdef RX_TS_OVERWRITE_EN
        exp_head = 2;
`else
        exp_head = 1;
`endif
        chk("ovf_full", 80'(full_o), 80'd1);
        chk("ovf_cnt1", 80'(ovf_cnt_o), 80'd1);
        chk("ovf_head", 80'(out_seqid_o), 80'(exp_head));

        cyc(0, 1, 0, 0, 1, 0, 0, z);
        for (int i = 10; i <= 13; i++) cyc(0, 1, 1, 0, 0, 0, 0, mk(16'(i)));
        cyc(0, 1, 1, 1, 0, 0, 0, mk(16'd14));
        settle();
        chk("capop_level", 80'(level_o), 80'd4);
        chk("capop_ovf", 80'(ovf_cnt_o), 80'd0);
        chk("capop_head", 80'(out_seqid_o), 80'd11);

        cyc(0, 1, 0, 0, 1, 1, 2, z);
        cyc(0, 1, 1, 0, 0, 1, 2, mk(16'h31));
        settle();
        chk("int_one", 80'(int_o), 80'd0);
        cyc(0, 1, 1, 0, 0, 1, 2, mk(16'h32));
        settle();
        chk("int_thresh", 80'(int_o), 80'd1);
        cyc(0, 1, 0, 1, 0, 1, 2, z);
        settle();
        chk("int_pop", 80'(int_o), 80'd0);

        cyc(0, 1, 1, 0, 0, 1, 2, mk(16'h33));
        cyc(0, 1, 1, 0, 0, 1, 2, mk(16'h34));
        settle();
        chk("clr_pre_level", 80'(level_o), 80'd3);
        cyc(0, 1, 1, 0, 1, 1, 2, mk(16'h35));
        settle();
        chk("clr_level", 80'(level_o), 80'd0);
        chk("clr_ovf", 80'(ovf_cnt_o), 80'd0);
        chk("clr_valid", 80'(out_valid_o), 80'd0);
        chk("clr_int", 80'(int_o), 80'd0);

        cyc(0, 1, 1, 0, 0, 0, 0, mk(16'h21));
        cyc(0, 1, 1, 0, 0, 0, 0, mk(16'h22));
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0, 0, mk(16'h40 + 16'(i)));
        settle();
        chk("en_level", 80'(level_o), 80'd2);
        chk("en_head", 80'(out_seqid_o), 80'h21);
        for (int i = 0; i < 302; i++) cyc(0, 1, 1, 0, 0, 0, 0, mk(16'h100 + 16'(i)));
        settle();
        chk("sat_ovf", 80'(ovf_cnt_o), 80'd255);
        chk("sat_full", 80'(full_o), 80'd1);

        // Reset mid-operation: the next capture must land in a clean queue.
        cyc(1, 1, 0, 0, 0, 0, 0, z);
        cyc(0, 1, 1, 0, 0, 0, 0, mk(16'h77));
        settle();
        chk("rst_mid_level", 80'(level_o), 80'd1);
        chk("rst_mid_head", 80'(out_seqid_o), 80'h77);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ie = $urandom_range(0, 1) != 0;
            e.ts  = {16'($urandom), $urandom, $urandom};
            e.seq = 16'($urandom);
            e.mt  = 4'($urandom);
            e.sd  = 4'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0, ie, $urandom_range(0, DEPTH), e);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, z);
        settle();
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_ts_queue.md
RX_TS_QUEUE -- requirements
Module: rx_ts_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, 2..64.
REQ-002 SHALL have parameter AW, default 2, meaning log2(DEPTH).
REQ-003 SHALL have port rx_clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rx_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port rx_clk_en_i, input, 1 bit, clock enable for gmii/mii adaptation; when low, no state changes.
REQ-006 SHALL have ports cap_valid_i (input, 1), cap_ts_i (input, 80: 48 s + 32 ns), cap_seqid_i (input, 16), cap_msgtype_i (input, 4), cap_sdoid_i (input, 4): capture write strobe and entry fields.
REQ-007 SHALL have ports pop_i (input, 1, remove head) and clr_i (input, 1, synchronous flush).
REQ-008 SHALL have ports int_en_i (input, 1) and thresh_i (input, AW+1, interrupt level threshold).
REQ-009 SHALL have ports out_valid_o (output, 1), out_ts_o (output, 80), out_seqid_o (output, 16), out_msgtype_o (output, 4), out_sdoid_o (output, 4): head entry.
REQ-010 SHALL have ports level_o (output, AW+1), full_o (output, 1), ovf_cnt_o (output, 8, saturating drop/overwrite count), int_o (output, 1).

Function
REQ-011 SHALL be a first-word-fall-through FIFO: out_* reflect the head entry whenever out_valid_o=1; out_valid_o = (level_o != 0).
REQ-012 SHALL take one cycle of latency: a capture at edge N into an empty queue gives out_valid_o=1 after edge N.
REQ-013 SHALL act on pop_i only when out_valid_o=1; pop on empty is ignored with no side effect.
REQ-014 SHALL, on simultaneous capture and pop, perform both; level unchanged; no overflow even when full.
REQ-015 SHALL wrap pointers modulo DEPTH using AW-bit pointers; level_o is tracked as a separate AW+1-bit count.
REQ-016 SHALL assert full_o when level_o == DEPTH.
REQ-017 SHALL, on a capture when full without a pop, apply the overflow policy of REQ-025/026 and increment ovf_cnt_o, saturating at 255.
REQ-018 SHALL give clr_i priority over capture and pop in the same cycle: pointers, level, ovf_cnt_o and the sticky overflow flag go to 0; the capture is discarded.
REQ-019 SHALL set the internal sticky overflow flag on any overflow event, cleared only by clr_i or reset.
REQ-020 SHALL register int_o = int_en_i & ((thresh_i != 0 & level >= thresh_i) | sticky overflow), evaluated on next-state values, so int_o is valid the cycle after the triggering edge.
REQ-021 SHALL ignore cap_valid_i, pop_i and clr_i while rx_clk_en_i=0; int_o holds its value.

Reset
REQ-022 SHALL, with rx_rst_n low, asynchronously clear pointers, level_o, full_o, ovf_cnt_o, the sticky flag and int_o to 0; out_valid_o=0.
REQ-023 SHALL reset out_ts_o, out_seqid_o, out_msgtype_o and out_sdoid_o to 0 (storage array reset to 0).
REQ-024 SHALL, on reset asserted mid-operation, discard all queued entries; the first capture after deassertion lands in entry 0.

Configuration
REQ-025 SHALL, with macro RX_TS_OVERWRITE_EN defined, on overflow discard the oldest entry and store the new one (read and write pointers both advance; level stays DEPTH).
REQ-026 SHALL, without RX_TS_OVERWRITE_EN, on overflow drop the new capture and leave the queue unchanged.

Verification
REQ-027 SHALL cover: reset, capture ts=0x000000000001_3B9AC9FF, seqid=0x0005 -> next cycle out_valid_o=1, out_ts_o matches, level_o=1.
REQ-028 SHALL cover: DEPTH=4, capture seqid 1..5 without pop -> full_o=1, ovf_cnt_o=1; head seqid=2 with macro defined, head seqid=1 without it.
REQ-029 SHALL cover: full queue plus simultaneous capture and pop -> level_o stays 4, ovf_cnt_o stays 0, head advances by one.
REQ-030 SHALL cover: thresh_i=2, int_en_i=1, two captures -> int_o=1 the cycle after the second; one pop -> int_o=0.
REQ-031 SHALL cover: clr_i together with cap_valid_i on a queue at level 3 -> level_o=0, ovf_cnt_o=0, out_valid_o=0, int_o=0.
REQ-032 SHALL cover: rx_clk_en_i=0 during captures and pops -> level_o and out_* unchanged; 300 overflows -> ovf_cnt_o=255.
